// File: rtl/delay_arb_pkg.sv
// Shared types and constants for the 2-second delay arbiter.
// Requester indices name the game FSMs wired to each request bit.
package delay_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_e;

  localparam int REQ_DEAL   = 0;
  localparam int REQ_DEALER = 1;
  localparam int REQ_SHOW   = 2;
  localparam int REQ_SPARE  = 3;

endpackage

// File: rtl/delay_arb_pick.sv
// Combinational winner selection for the delay arbiter.
// DELAY_ARB_ROUND_ROBIN_EN: round-robin from i_Ptr; otherwise lowest index wins.
module delay_arb_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_Req,
`ifdef DELAY_ARB_ROUND_ROBIN_EN
  input  logic [$clog2(N_REQ)-1:0] i_Ptr,
`endif
  output logic [N_REQ-1:0]         o_Win,
  output logic                     o_Any
);

  assign o_Any = |i_Req;

`ifdef DELAY_ARB_ROUND_ROBIN_EN
  int rank;
  int best_rank;

  // Rank is the upward distance from the pointer; the smallest requesting rank wins.
  always_comb begin
    o_Win     = '0;
    rank      = 0;
    best_rank = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      rank = (i >= int'(i_Ptr)) ? (i - int'(i_Ptr)) : (i + N_REQ - int'(i_Ptr));
      if (i_Req[i] && (rank < best_rank)) begin
        best_rank = rank;
        o_Win     = '0;
        o_Win[i]  = 1'b1;
      end
    end
  end
`else
  assign o_Win = i_Req & (~i_Req + N_REQ'(1));
`endif

endmodule

// File: rtl/delay_arbiter.sv
// Shares the single 2-second delay counter among the game FSMs.
// DELAY_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed-priority arbitration.
//   state    | meaning
//   IDLE     | no owner; pick a winner from i_Req
//   CLEAR    | clearing counter, waiting for i_RstOK
//   RUN      | counter active, waiting for i_TwoSec
//   DONE     | pulse o_Done to owner, re-clear counter
//   ABORT    | owner dropped its request; re-clear counter
module delay_arbiter
  import delay_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk_2K,
  input  logic             i_ResetNeg,
  input  logic [N_REQ-1:0] i_Req,
  output logic [N_REQ-1:0] o_Grant,
  output logic [N_REQ-1:0] o_Done,
  output logic             o_ActCounter,
  output logic             o_RstCounter,
  input  logic             i_TwoSec,
  input  logic             i_RstOK,
  output logic             o_Busy
);

  if (PTR_W != $clog2(N_REQ)) begin : g_bad_ptr_w
    $error("delay_arbiter: PTR_W must equal clog2(N_REQ)");
  end

  state_e           state_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] done_q;
  logic             act_q;
  logic             rstc_q;
  logic             busy_q;

  logic [N_REQ-1:0] win_d;
  logic             any_d;
  logic             req_held;

  assign req_held = |(i_Req & grant_q);

`ifdef DELAY_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        ptr_d = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  delay_arb_pick #(.N_REQ(N_REQ)) u_pick (
    .i_Req (i_Req),
    .i_Ptr (ptr_q),
    .o_Win (win_d),
    .o_Any (any_d)
  );
`else
  delay_arb_pick #(.N_REQ(N_REQ)) u_pick (
    .i_Req (i_Req),
    .o_Win (win_d),
    .o_Any (any_d)
  );
`endif

  always_ff @(posedge clk_2K or posedge i_ResetNeg) begin
    if (i_ResetNeg) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      act_q   <= 1'b0;
      rstc_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DELAY_ARB_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (any_d) begin
            state_q <= ST_CLEAR;
            grant_q <= win_d;
            rstc_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // A dropped request beats a clear confirmation arriving in the same cycle.
          if (!req_held) begin
            state_q <= ST_ABORT;
          end else if (i_RstOK) begin
            state_q <= ST_RUN;
            rstc_q  <= 1'b0;
            act_q   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_TwoSec) begin
            state_q <= ST_DONE;
            act_q   <= 1'b0;
            rstc_q  <= 1'b1;
            done_q  <= grant_q;
          end else if (!req_held) begin
            state_q <= ST_ABORT;
            act_q   <= 1'b0;
            rstc_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          rstc_q  <= 1'b0;
          busy_q  <= 1'b0;
`ifdef DELAY_ARB_ROUND_ROBIN_EN
          ptr_q   <= ptr_d;
`endif
        end
        ST_ABORT: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          rstc_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          act_q   <= 1'b0;
          rstc_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Grant      = grant_q;
  assign o_Done       = done_q;
  assign o_ActCounter = act_q;
  assign o_RstCounter = rstc_q;
  assign o_Busy       = busy_q;

  a_act_rst_excl : assert property (@(posedge clk_2K) disable iff (i_ResetNeg)
    !(act_q && rstc_q));

  a_grant_stable : assert property (@(posedge clk_2K) disable iff (i_ResetNeg)
    (state_q == ST_CLEAR || state_q == ST_RUN) |=> $stable(grant_q));

endmodule

// File: tb/tb_delay_arbiter.sv
// Scoreboarded bench for delay_arbiter with a behavioural 2-second counter.
// Expected grants/dones are queued by the stimulus and popped by the monitor.
module tb_delay_arbiter;
  import delay_arb_pkg::*;

  localparam int TC = 4095;

  logic       clk_2K = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] done;
  logic       act;
  logic       rstc;
  logic       two_sec;
  logic       rst_ok;
  logic       busy;

  logic [11:0] cnt     = '0;
  logic        rstok_q = 1'b0;
  logic        hold_ok = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_grant_q[$];
  logic [3:0] exp_done_q[$];

  always #5 clk_2K = ~clk_2K;

  delay_arbiter #(.N_REQ(4), .PTR_W(2)) dut (
    .clk_2K       (clk_2K),
    .i_ResetNeg   (rst),
    .i_Req        (req),
    .o_Grant      (grant),
    .o_Done       (done),
    .o_ActCounter (act),
    .o_RstCounter (rstc),
    .i_TwoSec     (two_sec),
    .i_RstOK      (rst_ok),
    .o_Busy       (busy)
  );

  // Counter model: sync clear, count while active, clear confirmed one cycle later.
  always @(posedge clk_2K) begin
    if (rstc)     cnt <= '0;
    else if (act) cnt <= cnt + 12'd1;
    rstok_q <= rstc;
  end
  assign two_sec = (cnt == 12'(TC - 1));
  assign rst_ok  = rstok_q & ~hold_ok;

  function automatic logic [3:0] bit4(int i);
    logic [3:0] one;
    one  = 4'b0001;
    bit4 = one << i;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk_2K);
  endtask

  task automatic wait_done(int budget);
    int n;
    n = 0;
    while (done == 4'b0 && n < budget) begin
      @(negedge clk_2K);
      n++;
    end
    chk("wait_done_timeout", {31'b0, done != 4'b0}, 32'd1);
  endtask

  task automatic wait_act(int budget);
    int n;
    n = 0;
    while (!act && n < budget) begin
      @(negedge clk_2K);
      n++;
    end
    chk("wait_act_timeout", {31'b0, act}, 32'd1);
  endtask

  task automatic expect_delay(logic [3:0] g);
    exp_grant_q.push_back(g);
    exp_done_q.push_back(g);
  endtask

  // Monitor: pops expected grant on every new ownership and expected done on every pulse.
  initial begin
    logic [3:0] prev_grant;
    logic [3:0] prev_done;
    logic [3:0] e;
    int act_cnt;
    prev_grant = '0;
    prev_done  = '0;
    act_cnt    = 0;
    forever begin
      @(negedge clk_2K);
      if (!rst) begin
        chk("act_rst_exclusive", {31'b0, act & rstc}, 32'd0);
        chk("grant_onehot0", {31'b0, $countones(grant) > 1}, 32'd0);
        if (grant != 4'b0 && prev_grant == 4'b0) begin
          if (exp_grant_q.size() == 0) begin
            chk("unexpected_grant", {28'b0, grant}, 32'd0);
          end else begin
            e = exp_grant_q.pop_front();
            chk("grant", {28'b0, grant}, {28'b0, e});
          end
          act_cnt = 0;
        end
        if (act) act_cnt++;
        if (done != 4'b0) begin
          chk("done_width", {28'b0, prev_done}, 32'd0);
          if (exp_done_q.size() == 0) begin
            chk("unexpected_done", {28'b0, done}, 32'd0);
          end else begin
            e = exp_done_q.pop_front();
            chk("done", {28'b0, done}, {28'b0, e});
          end
          chk("done_act_cycles", act_cnt, TC);
          chk("done_matches_grant", {28'b0, done}, {28'b0, grant});
        end
      end
      prev_grant = grant;
      prev_done  = done;
    end
  end

  initial begin
    rst = 1'b1;
    req = '0;
    tick(2);
    chk("rst_grant", {28'b0, grant}, 32'd0);
    chk("rst_done", {28'b0, done}, 32'd0);
    chk("rst_act", {31'b0, act}, 32'd0);
    chk("rst_rstc", {31'b0, rstc}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    tick(1);

    // Contention on DEAL and SHOW held continuously.
`ifdef DELAY_ARB_ROUND_ROBIN_EN
    expect_delay(4'b0001); expect_delay(4'b0100); expect_delay(4'b0001);
`else
    expect_delay(4'b0001); expect_delay(4'b0001); expect_delay(4'b0001);
`endif
    req = bit4(REQ_DEAL) | bit4(REQ_SHOW);
    for (int i = 0; i < 3; i++) begin
      wait_done(TC + 50);
      if (i == 2) req = '0;
      tick(1);
    end
    tick(1);
    chk("contention_idle_busy", {31'b0, busy}, 32'd0);

    // Single request with latency checks.
    expect_delay(4'b0001);
    req = bit4(REQ_DEAL);
    tick(1);
    chk("single_clear_grant", {28'b0, grant}, 32'h1);
    chk("single_clear_rstc", {31'b0, rstc}, 32'd1);
    chk("single_clear_act", {31'b0, act}, 32'd0);
    chk("single_clear_busy", {31'b0, busy}, 32'd1);
    tick(1);
    chk("single_clear2_act", {31'b0, act}, 32'd0);
    tick(1);
    chk("single_run_act", {31'b0, act}, 32'd1);
    chk("single_run_rstc", {31'b0, rstc}, 32'd0);
    wait_done(TC + 50);
    req = '0;
    tick(2);
    chk("single_after_busy", {31'b0, busy}, 32'd0);
    chk("single_after_grant", {28'b0, grant}, 32'd0);
    chk("single_after_done", {28'b0, done}, 32'd0);

    // Abort: DEALER drops its request partway through RUN.
    exp_grant_q.push_back(4'b0010);
    req = bit4(REQ_DEALER);
    wait_act(20);
    tick(1000);
    req = '0;
    tick(1);
    chk("abort_rstc", {31'b0, rstc}, 32'd1);
    chk("abort_act", {31'b0, act}, 32'd0);
    chk("abort_done", {28'b0, done}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd1);
    tick(1);
    chk("abort_idle_rstc", {31'b0, rstc}, 32'd0);
    chk("abort_idle_busy", {31'b0, busy}, 32'd0);
    chk("abort_idle_grant", {28'b0, grant}, 32'd0);

    // Pointer left at DEALER by the abort; request drop coincides with terminal count.
`ifdef DELAY_ARB_ROUND_ROBIN_EN
    expect_delay(4'b0010);
`else
    expect_delay(4'b0001);
`endif
    req = bit4(REQ_DEAL) | bit4(REQ_DEALER);
    begin
      int n;
      n = 0;
      while (!two_sec && n < TC + 50) begin
        @(negedge clk_2K);
        n++;
      end
    end
    chk("sim_twosec_seen", {31'b0, two_sec}, 32'd1);
    req = '0;
    chk("sim_still_run", {31'b0, act}, 32'd1);
    wait_done(3);
    tick(2);
    chk("sim_after_busy", {31'b0, busy}, 32'd0);

    // Slow clear: confirmation withheld for 5 cycles.
    expect_delay(4'b0100);
    hold_ok = 1'b1;
    req = bit4(REQ_SHOW);
    tick(1);
    repeat (5) begin
      chk("slow_clear_rstc", {31'b0, rstc}, 32'd1);
      chk("slow_clear_act", {31'b0, act}, 32'd0);
      tick(1);
    end
    hold_ok = 1'b0;
    tick(1);
    chk("slow_run_act", {31'b0, act}, 32'd1);
    chk("slow_run_rstc", {31'b0, rstc}, 32'd0);
    wait_done(TC + 50);
    req = '0;
    tick(2);

    // Asynchronous reset in the middle of RUN.
    exp_grant_q.push_back(4'b1000);
    req = bit4(REQ_SPARE);
    wait_act(20);
    tick(200);
    #2 rst = 1'b1;
    #1;
    chk("arst_grant", {28'b0, grant}, 32'd0);
    chk("arst_act", {31'b0, act}, 32'd0);
    chk("arst_rstc", {31'b0, rstc}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {28'b0, done}, 32'd0);
    tick(2);
    expect_delay(4'b1000);
    rst = 1'b0;
    tick(1);
    chk("arst_fresh_grant", {28'b0, grant}, 32'h8);
    chk("arst_fresh_rstc", {31'b0, rstc}, 32'd1);
    chk("arst_fresh_act", {31'b0, act}, 32'd0);
    wait_done(TC + 50);
    req = '0;
    tick(2);
    chk("final_busy", {31'b0, busy}, 32'd0);
    chk("grant_queue_empty", exp_grant_q.size(), 32'd0);
    chk("done_queue_empty", exp_done_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/delay_arbiter.md
Name: delay_arbiter

Overview:
- Owns the single shared 2-second delay counter and shares it among several game-FSM requesters (deal pause, dealer-turn pause, result display hold, etc.).
- Sequences each delay as: clear the counter, confirm the clear, run it, detect terminal count, then pulse the winner's done flag.
- Sits between the game-control FSMs and the counter, driving its activate and clear inputs and consuming its two-second and reset-OK outputs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- PTR_W, 2, width of the arbitration pointer; must equal clog2(N_REQ).

Ports:
- clk_2K  input  1  2 kHz system clock.
- i_ResetNeg  input  1  reset, asynchronous, active-high.
- i_Req  input  N_REQ  level request per requester; held high until done or abandoned.
- o_Grant  output  N_REQ  one-hot current owner of the counter; all-zero when idle.
- o_Done  output  N_REQ  one-cycle pulse to the owner when its 2 s delay has expired.
- o_ActCounter  output  1  drives counter activate input.
- o_RstCounter  output  1  drives counter synchronous clear input.
- i_TwoSec  input  1  counter terminal-count flag.
- i_RstOK  input  1  counter confirmation that it is at zero.
- o_Busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, i_ResetNeg=1): state=IDLE, o_Grant=0, o_Done=0, o_ActCounter=0, o_RstCounter=0, o_Busy=0, pointer=0. All outputs are registered.
- States: IDLE, CLEAR, RUN, DONE, ABORT.
- IDLE: if any i_Req bit is set, latch the winner into o_Grant and go to CLEAR the next edge; otherwise stay.
- CLEAR: o_RstCounter=1. Go to RUN on the first edge where i_RstOK=1. If the granted i_Req drops, go to ABORT.
- RUN: o_ActCounter=1, o_RstCounter=0. On i_TwoSec=1, go to DONE. If the granted i_Req drops before that, go to ABORT. If both happen in the same cycle, DONE wins.
- DONE: one cycle. o_Done[grant]=1, o_ActCounter=0, o_RstCounter=1. Advance the pointer to grant+1 (mod N_REQ), clear o_Grant, return to IDLE.
- ABORT: one cycle. o_RstCounter=1, no o_Done. Pointer is not advanced. Clear o_Grant and return to IDLE.
- Latency: request in IDLE to o_ActCounter high is at least 2 cycles (IDLE then CLEAR). The total delay is CLEAR cycles + 4095 counting cycles + 1 DONE cycle.
- A request still high after its o_Done is treated as a new request. Rotation guarantees that any other pending requester is served first.
- o_Grant never changes while in CLEAR or RUN. Requests arriving during a delay simply wait, and no request is lost while it is held.
- o_ActCounter and o_RstCounter are never high in the same cycle.
- Reset mid-operation: immediate return to IDLE with outputs cleared. The in-flight delay is discarded and no o_Done is issued.

Optional Feature:
- Macro DELAY_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. The search starts at the pointer and wraps upward, so the first set i_Req bit at or after the pointer wins.
- Undefined: fixed priority, lowest index wins. The pointer register is removed and DONE does not update it.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package delay_arb_pkg holds:
  - state encoding constants ST_IDLE, ST_CLEAR, ST_RUN, ST_DONE, ST_ABORT (3-bit);
  - requester index constants REQ_DEAL=0, REQ_DEALER=1, REQ_SHOW=2, REQ_SPARE=3.
- One natural sub-module: delay_arb_pick, a combinational priority/round-robin selector taking (i_Req, pointer) and returning a one-hot winner plus an any-valid flag. The macro is applied inside it.

Test Plan:
- Single request: i_Req=0001 from IDLE, model counter returns i_RstOK after 1 cycle → o_Grant=0001, o_ActCounter high for 4095 cycles, o_Done=0001 for exactly 1 cycle, o_Busy low afterwards.
- Contention, RR build: i_Req=0101 held continuously → grants in order 0001, 0100, 0001, each followed by its own o_Done pulse. Fixed build: grants 0001 repeatedly.
- Abort: i_Req=0010 dropped at RUN cycle 1000 → no o_Done, o_RstCounter for 1 cycle, IDLE with pointer unchanged.
- Simultaneous i_TwoSec and request drop in the same cycle → o_Done pulse issued, DONE path taken.
- Slow clear: i_RstOK held low for 5 cycles → remain in CLEAR with o_RstCounter=1 and o_ActCounter=0, then RUN.
- Async reset asserted mid-RUN between clock edges → all outputs 0 immediately; after release with i_Req=1000, a fresh CLEAR begins.
